axil_protocol_checker: RTL and testbench

Parametrised AXI4-Lite compliance checker for CGRA testbenches and on-chip debug. It covers all five channels (AW, W, B, AR, R) and checks payload stability during stall, VALID dropping before READY, orphan responses, outstanding-transaction overflow and stall timeouts. Violations appear as synthesizable sticky flags, single-cycle pulses and a saturating counter. It attaches passively to any AXI4-Lite link between the host bridge and the CGRA register file.

---
 rtl/axil_chk_pkg.sv | 43 ++++
 rtl/axil_chk_channel.sv | 82 ++++++++
 rtl/axil_protocol_checker.sv | 163 ++++++++++++++++
 tb/tb_axil_protocol_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/axil_chk_pkg.sv
// Shared definitions for the AXI4-Lite protocol checker: error-vector layout and message names.
package axil_chk_pkg;

    localparam int unsigned ERR_W = 14;

    localparam int unsigned ERR_AW_STABLE = 0;
    localparam int unsigned ERR_AW_DROP   = 1;
    localparam int unsigned ERR_W_STABLE  = 2;
    localparam int unsigned ERR_W_DROP    = 3;
    localparam int unsigned ERR_B_STABLE  = 4;
    localparam int unsigned ERR_B_DROP    = 5;
    localparam int unsigned ERR_AR_STABLE = 6;
    localparam int unsigned ERR_AR_DROP   = 7;
    localparam int unsigned ERR_R_STABLE  = 8;
    localparam int unsigned ERR_R_DROP    = 9;
    localparam int unsigned ERR_B_ORPHAN  = 10;
    localparam int unsigned ERR_R_ORPHAN  = 11;
    localparam int unsigned ERR_OVERFLOW  = 12;
    localparam int unsigned ERR_TIMEOUT   = 13;

    typedef logic [ERR_W-1:0] err_vec_t;

    function automatic string err_name(input int unsigned idx);
        case (idx)
            ERR_AW_STABLE: return "AW_STABLE";
            ERR_AW_DROP:   return "AW_DROP";
            ERR_W_STABLE:  return "W_STABLE";
            ERR_W_DROP:    return "W_DROP";
            ERR_B_STABLE:  return "B_STABLE";
            ERR_B_DROP:    return "B_DROP";
            ERR_AR_STABLE: return "AR_STABLE";
            ERR_AR_DROP:   return "AR_DROP";
            ERR_R_STABLE:  return "R_STABLE";
            ERR_R_DROP:    return "R_DROP";
            ERR_B_ORPHAN:  return "B_ORPHAN";
            ERR_R_ORPHAN:  return "R_ORPHAN";
            ERR_OVERFLOW:  return "OVERFLOW";
            ERR_TIMEOUT:   return "TIMEOUT";
            default:       return "UNKNOWN";
        endcase
    endfunction

endpackage

// File: rtl/axil_chk_channel.sv
// Per-channel VALID/READY checker: payload stability, VALID drop and stall timeout.
// With AXIL_CHK_ASSERT_EN defined, violations also raise simulation-only $error messages.
module axil_chk_channel #(
    parameter int unsigned PAYLOAD_W      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic                 ready,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 stable_err,
    output logic                 drop_err,
    output logic                 timeout_err
);

    logic                 stall;
    logic                 stall_q;
    logic [PAYLOAD_W-1:0] payload_q;

    always_comb begin
        stall = valid && !ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            stall_q   <= stall;
            payload_q <= payload;
        end
    end

    // 4-state compare so an X/Z appearing on a stalled payload is reported as a change
    always_comb begin
        drop_err   = !rst && stall_q && !valid;
        stable_err = !rst && stall_q && valid && (payload !== payload_q);
    end

    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
        always_comb begin
            timeout_err = 1'b0;
        end
    end else begin : g_timeout
        localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

        logic [TW-1:0] stall_cnt;
        logic          fired_q;

        // fired_q keeps a saturated counter from re-flagging until the stall ends
        always_ff @(posedge clk) begin
            if (rst || !stall) begin
                stall_cnt <= '0;
                fired_q   <= 1'b0;
            end else if (stall_cnt != LIMIT) begin
                stall_cnt <= stall_cnt + TW'(1);
            end else begin
                fired_q <= 1'b1;
            end
        end

        always_comb begin
            timeout_err = !rst && (stall_cnt == LIMIT) && !fired_q;
        end
    end

`ifdef AXIL_CHK_ASSERT_EN
    always_ff @(posedge clk) begin
        if (stable_err)
            $error("[AXIL CHK] %m STABLE current=%h locked=%h at %0t", payload, payload_q, $time);
        if (drop_err)
            $error("[AXIL CHK] %m DROP locked=%h at %0t", payload_q, $time);
        if (timeout_err)
            $error("[AXIL CHK] %m TIMEOUT payload=%h at %0t", payload, $time);
    end
`else
    // flags only
`endif

endmodule

// File: rtl/axil_protocol_checker.sv
// Passive AXI4-Lite compliance checker: five channel checkers plus outstanding/orphan tracking.
// Define AXIL_CHK_ASSERT_EN for simulation-only $error reporting of every detection.
module axil_protocol_checker
    import axil_chk_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_OUT        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           err_clr,
    input  logic [ADDR_W-1:0]              awaddr,
    input  logic                           awvalid,
    input  logic                           awready,
    input  logic [DATA_W-1:0]              wdata,
    input  logic [DATA_W/8-1:0]            wstrb,
    input  logic                           wvalid,
    input  logic                           wready,
    input  logic [1:0]                     bresp,
    input  logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_W-1:0]              araddr,
    input  logic                           arvalid,
    input  logic                           arready,
    input  logic [DATA_W-1:0]              rdata,
    input  logic [1:0]                     rresp,
    input  logic                           rvalid,
    input  logic                           rready,
    output logic [ERR_W-1:0]               err_sticky,
    output logic [ERR_W-1:0]               err_pulse,
    output logic [CNT_W-1:0]               err_count,
    output logic [$clog2(MAX_OUT+1)-1:0]   wr_outstanding,
    output logic [$clog2(MAX_OUT+1)-1:0]   rd_outstanding
);

    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0] MAX_C = OW'(MAX_OUT);

    logic aw_stable, aw_drop, aw_to;
    logic w_stable,  w_drop,  w_to;
    logic b_stable,  b_drop,  b_to;
    logic ar_stable, ar_drop, ar_to;
    logic r_stable,  r_drop,  r_to;

    axil_chk_channel #(.PAYLOAD_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_aw (
        .clk(clk), .rst(rst), .valid(awvalid), .ready(awready), .payload(awaddr),
        .stable_err(aw_stable), .drop_err(aw_drop), .timeout_err(aw_to)
    );

    axil_chk_channel #(.PAYLOAD_W(DATA_W + DATA_W/8), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_w (
        .clk(clk), .rst(rst), .valid(wvalid), .ready(wready), .payload({wdata, wstrb}),
        .stable_err(w_stable), .drop_err(w_drop), .timeout_err(w_to)
    );

    axil_chk_channel #(.PAYLOAD_W(2), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_b (
        .clk(clk), .rst(rst), .valid(bvalid), .ready(bready), .payload(bresp),
        .stable_err(b_stable), .drop_err(b_drop), .timeout_err(b_to)
    );

    axil_chk_channel #(.PAYLOAD_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ar (
        .clk(clk), .rst(rst), .valid(arvalid), .ready(arready), .payload(araddr),
        .stable_err(ar_stable), .drop_err(ar_drop), .timeout_err(ar_to)
    );

    axil_chk_channel #(.PAYLOAD_W(DATA_W + 2), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_r (
        .clk(clk), .rst(rst), .valid(rvalid), .ready(rready), .payload({rdata, rresp}),
        .stable_err(r_stable), .drop_err(r_drop), .timeout_err(r_to)
    );

    logic [OW-1:0] aw_cnt, w_cnt, ar_cnt;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic          b_orphan, r_orphan, b_dec, r_dec, overflow;
    err_vec_t      det;

    // Net-zero when inc and dec coincide; saturates at MAX_OUT
    function automatic logic [OW-1:0] next_cnt(input logic [OW-1:0] cnt,
                                               input logic inc, input logic dec);
        if (inc && !dec)
            return (cnt == MAX_C) ? cnt : cnt + OW'(1);
        else if (dec && !inc)
            return cnt - OW'(1);
        else
            return cnt;
    endfunction

    // Orphan judgement uses start-of-cycle counts, so a same-cycle AW/W does not cover a B
    always_comb begin
        aw_hs    = awvalid && awready;
        w_hs     = wvalid && wready;
        b_hs     = bvalid && bready;
        ar_hs    = arvalid && arready;
        r_hs     = rvalid && rready;
        b_orphan = b_hs && ((aw_cnt == '0) || (w_cnt == '0));
        r_orphan = r_hs && (ar_cnt == '0);
        b_dec    = b_hs && !b_orphan;
        r_dec    = r_hs && !r_orphan;
        overflow = (aw_hs && (aw_cnt == MAX_C)) ||
                   (w_hs  && (w_cnt  == MAX_C)) ||
                   (ar_hs && (ar_cnt == MAX_C));
    end

    always_comb begin
        det = '0;
        if (!rst) begin
            det[ERR_AW_STABLE] = aw_stable;
            det[ERR_AW_DROP]   = aw_drop;
            det[ERR_W_STABLE]  = w_stable;
            det[ERR_W_DROP]    = w_drop;
            det[ERR_B_STABLE]  = b_stable;
            det[ERR_B_DROP]    = b_drop;
            det[ERR_AR_STABLE] = ar_stable;
            det[ERR_AR_DROP]   = ar_drop;
            det[ERR_R_STABLE]  = r_stable;
            det[ERR_R_DROP]    = r_drop;
            det[ERR_B_ORPHAN]  = b_orphan;
            det[ERR_R_ORPHAN]  = r_orphan;
            det[ERR_OVERFLOW]  = overflow;
            det[ERR_TIMEOUT]   = aw_to || w_to || b_to || ar_to || r_to;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_cnt     <= '0;
            w_cnt      <= '0;
            ar_cnt     <= '0;
            err_pulse  <= '0;
            err_sticky <= '0;
            err_count  <= '0;
        end else begin
            aw_cnt     <= next_cnt(aw_cnt, aw_hs, b_dec);
            w_cnt      <= next_cnt(w_cnt, w_hs, b_dec);
            ar_cnt     <= next_cnt(ar_cnt, ar_hs, r_dec);
            err_pulse  <= det;
            err_sticky <= (err_sticky & ~{ERR_W{err_clr}}) | det;
            if (err_clr)
                err_count <= (|det) ? CNT_W'(1) : '0;
            else if ((|det) && (err_count != '1))
                err_count <= err_count + CNT_W'(1);
        end
    end

    always_comb begin
        wr_outstanding = aw_cnt;
        rd_outstanding = ar_cnt;
    end

`ifdef AXIL_CHK_ASSERT_EN
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < ERR_W; i++) begin
            if (det[i])
                $error("[AXIL CHK] %s aw_cnt=%0d w_cnt=%0d ar_cnt=%0d at %0t",
                       err_name(i), aw_cnt, w_cnt, ar_cnt, $time);
        end
    end
`else
    // flags only
`endif

endmodule

// File: tb/tb_axil_protocol_checker.sv
// Directed self-checking bench for axil_protocol_checker (MAX_OUT=4, TIMEOUT_CYCLES=8).
module tb_axil_protocol_checker;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned TO      = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned OW      = $clog2(MAX_OUT + 1);

    logic              clk = 1'b0;
    logic              rst, err_clr;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [DATA_W-1:0] wdata, rdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [1:0]        bresp, rresp;
    logic [13:0]       err_sticky, err_pulse;
    logic [CNT_W-1:0]  err_count;
    logic [OW-1:0]     wr_outstanding, rd_outstanding;

    int vectors = 0;
    int miscompares = 0;

    axil_protocol_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT),
        .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .err_clr(err_clr),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .err_sticky(err_sticky), .err_pulse(err_pulse), .err_count(err_count),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_err(input string tag, input logic [31:0] pulse,
                             input logic [31:0] sticky, input logic [31:0] count);
        check({tag, ".pulse"}, 32'(err_pulse), pulse);
        check({tag, ".sticky"}, 32'(err_sticky), sticky);
        check({tag, ".count"}, 32'(err_count), count);
    endtask

    task automatic idle();
        err_clr = 1'b0;
        awaddr = '0; awvalid = 1'b0; awready = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; wready = 1'b0;
        bresp = '0; bvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; arready = 1'b0;
        rdata = '0; rresp = '0; rvalid = 1'b0; rready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_err("reset", 0, 0, 0);
        check("reset.wr_out", 32'(wr_outstanding), 0);
        check("reset.rd_out", 32'(rd_outstanding), 0);

        // AW stall with address change on the second stall cycle
        awvalid = 1'b1; awaddr = 32'h100;
        tick();
        check_err("aw_stall1", 0, 0, 0);
        awaddr = 32'h104;
        tick();
        check_err("aw_change", 14'h0001, 14'h0001, 1);
        tick();
        check_err("aw_stall3", 0, 14'h0001, 1);
        awready = 1'b1;
        tick();
        check("aw_hs.wr_out", 32'(wr_outstanding), 1);
        check("aw_hs.pulse", 32'(err_pulse), 0);
        do_reset();
        check("midreset.wr_out", 32'(wr_outstanding), 0);
        check("midreset.sticky", 32'(err_sticky), 0);

        // W VALID dropped while stalled
        wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        tick();
        check("w_stall1.pulse", 32'(err_pulse), 0);
        tick();
        check("w_stall2.pulse", 32'(err_pulse), 0);
        wvalid = 1'b0;
        tick();
        check_err("w_drop", 14'h0008, 14'h0008, 1);
        tick();
        check_err("w_after_drop", 0, 14'h0008, 1);

        // Orphan B and R
        do_reset();
        bvalid = 1'b1; bready = 1'b1;
        tick();
        check_err("b_orphan", 14'h0400, 14'h0400, 1);
        check("b_orphan.wr_out", 32'(wr_outstanding), 0);
        bvalid = 1'b0; bready = 1'b0;
        rvalid = 1'b1; rready = 1'b1; rdata = 32'h5A5A5A5A;
        tick();
        check_err("r_orphan", 14'h0800, 14'h0C00, 2);
        check("r_orphan.rd_out", 32'(rd_outstanding), 0);

        // Read overflow: five ARs without an R
        do_reset();
        arvalid = 1'b1; arready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            araddr = 32'(i * 4);
            tick();
            check("ovf_fill.rd_out", 32'(rd_outstanding), 32'(i));
            check("ovf_fill.pulse", 32'(err_pulse), 0);
        end
        araddr = 32'h20;
        tick();
        check_err("ovf", 14'h1000, 14'h1000, 1);
        check("ovf.rd_out", 32'(rd_outstanding), 4);

        // AR stall timeout: single pulse nine cycles after the stall begins
        do_reset();
        arvalid = 1'b1; arready = 1'b0; araddr = 32'h40;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("timeout.pulse", 32'(err_pulse), (k == 9) ? 32'h2000 : 32'h0);
        end
        check("timeout.sticky", 32'(err_sticky), 14'h2000);
        check("timeout.count", 32'(err_count), 1);

        // err_clr racing a new W_STABLE, then legal traffic
        do_reset();
        bvalid = 1'b1; bready = 1'b1;
        tick();
        check_err("clr_pre", 14'h0400, 14'h0400, 1);
        bvalid = 1'b0; bready = 1'b0;
        wvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF;
        tick();
        check("clr_wstall.pulse", 32'(err_pulse), 0);
        wdata = 32'h22222222; err_clr = 1'b1;
        tick();
        check_err("clr_race", 14'h0004, 14'h0004, 1);
        err_clr = 1'b0; wready = 1'b1;
        tick();
        check("w_hs.pulse", 32'(err_pulse), 0);
        wvalid = 1'b0; wready = 1'b0;
        awvalid = 1'b1; awready = 1'b1; awaddr = 32'h200;
        tick();
        check("legal_aw.wr_out", 32'(wr_outstanding), 1);
        awvalid = 1'b0; awready = 1'b0;
        bvalid = 1'b1; bready = 1'b1; bresp = 2'b00;
        tick();
        check("legal_b.wr_out", 32'(wr_outstanding), 0);
        check("legal_b.pulse", 32'(err_pulse), 0);
        bvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b1; arready = 1'b1; araddr = 32'h300;
        tick();
        check("legal_ar.rd_out", 32'(rd_outstanding), 1);
        arvalid = 1'b0; arready = 1'b0;
        rvalid = 1'b1; rready = 1'b1; rdata = 32'hCAFEF00D;
        tick();
        check("legal_r.rd_out", 32'(rd_outstanding), 0);
        rvalid = 1'b0; rready = 1'b0;
        tick();
        check_err("legal_end", 0, 14'h0004, 1);

        err_clr = 1'b1;
        tick();
        check_err("clr_only", 0, 0, 0);
        err_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
